// File: rtl/enoc_input_unit_if.sv
// Router input-port bundle: upstream packet link plus
// head/request/grant signals toward switch control.
interface enoc_input_unit_if #(
  parameter int DATA_W = 32,
  parameter int M      = 5
);
  logic [DATA_W-1:0] i_data;
  logic              i_data_val;
  logic              o_en;
  logic [DATA_W-1:0] o_data;
  logic              o_data_val;
  logic [M-1:0]      o_output_req;
  logic              i_input_grant;
  logic              o_overflow;

  modport slave (
    input  i_data, i_data_val, i_input_grant,
    output o_en, o_data, o_data_val,
    output o_output_req, o_overflow
  );

  modport master (
    output i_data, i_data_val, i_input_grant,
    input  o_en, o_data, o_data_val,
    input  o_output_req, o_overflow
  );
endinterface

// File: rtl/enoc_input_unit.sv
// ENoC router input unit: packet FIFO + XY route request.
// Define ENOC_ROUTE_REG_EN to register the route computation.
module enoc_input_unit #(
  parameter int DEPTH   = 8,
  parameter int X_NODES = 4,
  parameter int Y_NODES = 4,
  parameter int X_LOC   = 0,
  parameter int Y_LOC   = 0,
  parameter int DATA_W  = 32,
  parameter int M       = 5
) (
  input  logic clk,
  input  logic reset_n,
  input  logic ce,
  enoc_input_unit_if.slave io
);

  localparam int AW = $clog2(DEPTH);
  localparam int XW = $clog2(X_NODES);
  localparam int YW = $clog2(Y_NODES);
  localparam logic [XW-1:0] LX = XW'(X_LOC);
  localparam logic [YW-1:0] LY = YW'(Y_LOC);
  localparam logic [AW:0] EN_MAX = (AW+1)'(DEPTH - 2);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW:0]       r_wr_ptr;
  logic [AW:0]       r_rd_ptr;
  logic              r_en;
  logic              r_ovf;

  logic [AW:0]       w_count;
  logic [AW:0]       w_count_nxt;
  logic              w_empty;
  logic              w_full;
  logic              w_pop;
  logic              w_push;
  logic              w_xeq;
  logic [DATA_W-1:0] w_head;
  logic [XW-1:0]     w_dx;
  logic [YW-1:0]     w_dy;
  logic [M-1:0]      w_route;
  logic [M-1:0]      w_req;

  assign w_count = r_wr_ptr - r_rd_ptr;
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  assign w_head = r_mem[r_rd_ptr[AW-1:0]];
  assign w_dx   = w_head[DATA_W-1 -: XW];
  assign w_dy   = w_head[DATA_W-1-XW -: YW];
  assign w_xeq  = (w_dx == LX);

  // XY order: resolve x first, then y; y grows southward
  always_comb begin
    w_route = '0;
    unique case (1'b1)
      (w_dx > LX):           w_route[2] = 1'b1;
      (w_dx < LX):           w_route[4] = 1'b1;
      (w_xeq && w_dy > LY):  w_route[3] = 1'b1;
      (w_xeq && w_dy < LY):  w_route[1] = 1'b1;
      default:               w_route[0] = 1'b1;
    endcase
  end

`ifdef ENOC_ROUTE_REG_EN
  logic [M-1:0] r_route;
  logic         r_rv;

  // route-valid drops on pop, giving a one-cycle bubble
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_route <= '0;
      r_rv    <= 1'b0;
    end else if (ce) begin
      if (w_pop || w_empty) begin
        r_rv <= 1'b0;
      end else begin
        r_route <= w_route;
        r_rv    <= 1'b1;
      end
    end
  end

  assign w_req = (r_rv && !w_empty) ? r_route : '0;
`else
  assign w_req = w_empty ? '0 : w_route;
`endif

  assign w_pop  = ce && io.i_input_grant && (|w_req);
  assign w_push = ce && io.i_data_val && (!w_full || w_pop);

  assign w_count_nxt = w_count
                     + (AW+1)'(w_push)
                     - (AW+1)'(w_pop);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= io.i_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_en     <= 1'b1;
      r_ovf    <= 1'b0;
    end else if (ce) begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (io.i_data_val && !w_push) begin
        r_ovf <= 1'b1;
      end
      r_en <= (w_count_nxt <= EN_MAX);
    end
  end

  assign io.o_data       = w_empty ? '0 : w_head;
  assign io.o_data_val   = !w_empty;
  assign io.o_output_req = w_req;
  assign io.o_en         = r_en;
  assign io.o_overflow   = r_ovf;

endmodule

// File: tb/tb_enoc_input_unit.sv
// Scoreboard bench for enoc_input_unit at router (1,1),
// 4x4 mesh, DEPTH 8, combinational route build.
module tb_enoc_input_unit;

  localparam int DEPTH  = 8;
  localparam int DATA_W = 32;
  localparam int M      = 5;
  localparam int XL     = 1;
  localparam int YL     = 1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic ce = 1'b1;

  enoc_input_unit_if #(.DATA_W(DATA_W), .M(M)) bus ();

  enoc_input_unit #(
    .DEPTH(DEPTH), .X_NODES(4), .Y_NODES(4),
    .X_LOC(XL), .Y_LOC(YL), .DATA_W(DATA_W), .M(M)
  ) dut (
    .clk(clk), .reset_n(reset_n), .ce(ce), .io(bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [DATA_W-1:0] exp_q[$];
  int  mcnt = 0;
  bit  movf = 1'b0;
  bit  armed = 1'b0;
  int  e_cnt = 0;
  bit  e_ovf = 1'b0;
  bit  e_pop = 1'b0;

  task automatic chk(string name, logic [63:0] act,
                     logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h",
                  name, act, req);
  endtask

  // destination fields: x at [31:30], y at [29:28]
  function automatic logic [4:0] ref_route(
      logic [DATA_W-1:0] p);
    int dx;
    int dy;
    dx = int'(p[31:30]);
    dy = int'(p[29:28]);
    if (dx > XL) return 5'b00100;
    if (dx < XL) return 5'b10000;
    if (dy > YL) return 5'b01000;
    if (dy < YL) return 5'b00010;
    return 5'b00001;
  endfunction

  function automatic logic [DATA_W-1:0] pkt(
      int dx, int dy, int tag);
    logic [DATA_W-1:0] p;
    p = DATA_W'(tag);
    p[31:30] = 2'(dx);
    p[29:28] = 2'(dy);
    return p;
  endfunction

  // one clock of stimulus; the model decides what the FIFO does
  task automatic step(bit c, bit v, bit g,
                      logic [DATA_W-1:0] d);
    bit pop;
    bit push;
    @(posedge clk);
    #1;
    ce = c;
    bus.i_data_val = v;
    bus.i_input_grant = g;
    bus.i_data = d;
    e_cnt = mcnt;
    e_ovf = movf;
    pop  = c && g && (mcnt > 0);
    push = c && v && ((mcnt < DEPTH) || pop);
    e_pop = pop;
    if (c && v && !push) movf = 1'b1;
    mcnt = mcnt + int'(push) - int'(pop);
    if (push) exp_q.push_back(d);
    armed = 1'b1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, '0);
  endtask

  always @(negedge clk) begin
    if (armed && reset_n) begin
      chk("data_val", 64'(bus.o_data_val), 64'(e_cnt > 0));
      chk("en", 64'(bus.o_en), 64'((DEPTH - e_cnt) >= 2));
      chk("overflow", 64'(bus.o_overflow), 64'(e_ovf));
      if (e_cnt > 0) begin
        chk("head_data", 64'(bus.o_data), 64'(exp_q[0]));
        chk("req", 64'(bus.o_output_req),
            64'(ref_route(exp_q[0])));
        if (e_pop) void'(exp_q.pop_front());
      end else begin
        chk("req_empty", 64'(bus.o_output_req), 64'(0));
      end
    end
  end

  task automatic chk_reset_state(string tag);
    chk({tag, "_en"}, 64'(bus.o_en), 64'(1));
    chk({tag, "_val"}, 64'(bus.o_data_val), 64'(0));
    chk({tag, "_req"}, 64'(bus.o_output_req), 64'(0));
    chk({tag, "_ovf"}, 64'(bus.o_overflow), 64'(0));
    chk({tag, "_data"}, 64'(bus.o_data), 64'(0));
  endtask

  initial begin
    bus.i_data = '0;
    bus.i_data_val = 1'b0;
    bus.i_input_grant = 1'b0;
    #12;
    chk_reset_state("rst");
    @(negedge clk);
    reset_n = 1'b1;

    // single east packet, then grant
    step(1'b1, 1'b1, 1'b0, pkt(3, 1, 1));
    step(1'b1, 1'b0, 1'b1, '0);
    idle(1);

    // route sweep with grant every cycle
    step(1'b1, 1'b1, 1'b1, pkt(0, 2, 2));
    step(1'b1, 1'b1, 1'b1, pkt(1, 0, 3));
    step(1'b1, 1'b1, 1'b1, pkt(1, 3, 4));
    step(1'b1, 1'b1, 1'b1, pkt(1, 1, 5));
    step(1'b1, 1'b0, 1'b1, '0);
    idle(1);

    // grant while empty; ce low with a write pending
    step(1'b1, 1'b0, 1'b1, '0);
    step(1'b0, 1'b1, 1'b1, pkt(2, 2, 6));
    step(1'b0, 1'b1, 1'b0, pkt(2, 2, 7));
    idle(1);

    // fill to 8, write+grant at full, then overflow
    for (int i = 0; i < 8; i++)
      step(1'b1, 1'b1, 1'b0, pkt(i % 4, (i + 1) % 4, 16 + i));
    step(1'b1, 1'b1, 1'b1, pkt(3, 3, 24));
    step(1'b1, 1'b1, 1'b0, pkt(0, 0, 25));
    idle(1);
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 1'b1, '0);
    idle(1);

    // randomized traffic, including ce gaps
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 9) != 0),
           $urandom_range(0, 1) == 1,
           $urandom_range(0, 2) != 0,
           $urandom);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b1, '0);

    // async reset with 5 packets stored
    for (int i = 0; i < 5; i++)
      step(1'b1, 1'b1, 1'b0, pkt(2, 0, 40 + i));
    idle(1);
    @(posedge clk);
    #3;
    armed = 1'b0;
    reset_n = 1'b0;
    #1;
    chk_reset_state("async_rst");
    exp_q.delete();
    mcnt = 0;
    movf = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;

    // traffic after reset
    step(1'b1, 1'b1, 1'b0, pkt(1, 3, 50));
    step(1'b1, 1'b1, 1'b1, pkt(0, 1, 51));
    step(1'b1, 1'b0, 1'b1, '0);
    step(1'b1, 1'b0, 1'b1, '0);
    idle(1);
    @(negedge clk);
    chk("drained_q", 64'(exp_q.size()), 64'(0));
    chk("drained_val", 64'(bus.o_data_val), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
